// File: rtl/uart_printf_pkg.sv
// Shared types and constants for the printf arbiter.
//   state_t  : arbiter FSM states (EOL states used only with UART_PRINTF_NEWLINE_EN)
//   ASCII_*  : end-of-line bytes
//   byte_sel : byte index of the cnt-th transmitted byte, MSB byte first
package uart_printf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        EOL_CR = 2'd2,
        EOL_LF = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Byte lane holding the cnt-th byte on the wire (byte 0 on the wire is the top lane).
    function automatic int unsigned byte_sel(input int unsigned cnt, input int unsigned data_num);
        return data_num - 32'd1 - cnt;
    endfunction

endpackage

// File: rtl/uart_printf_arbiter_rr.sv
// Combinational round-robin arbiter: rotate requests by ptr, pick the lowest
// set bit, rotate the winner back to an absolute index.
//   req     : request vector
//   ptr     : highest-priority index
//   grant_c : one-hot winner (0 when no request)
//   idx_c   : binary winner index
//   any_c   : at least one request present
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [PTR_W-1:0]   idx_c,
    output logic               any_c
);

    logic [2*NUM_REQ-1:0] dbl_c;
    logic [NUM_REQ-1:0]   rot_c;

    always_comb begin
        logic found;
        int   sum;
        dbl_c   = {req, req} >> ptr;
        rot_c   = dbl_c[NUM_REQ-1:0];
        any_c   = |req;
        idx_c   = '0;
        grant_c = '0;
        found   = 1'b0;
        sum     = 0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (rot_c[i] && !found) begin
                found = 1'b1;
                sum   = i + int'(ptr);
                if (sum >= int'(NUM_REQ)) sum = sum - int'(NUM_REQ);
                idx_c = PTR_W'(sum);
            end
        end
        if (any_c) grant_c = NUM_REQ'(1) << idx_c;
    end

endmodule

// File: rtl/uart_printf_arbiter.sv
// Shares one uart_tx byte channel among NUM_REQ printf sources. Each source
// has a one-deep holding slot; a round-robin winner is serialized MSB byte
// first over the valid/ready handshake.
// Optional: UART_PRINTF_NEWLINE_EN appends CR, LF after every message.
//   clk, rst_n      : clock (sys_clk) and async active-low reset
//   printf_i        : per-source 1-cycle request strobe
//   send_data_i     : source k message at [k*DATA_NUM*8 +: DATA_NUM*8]
//   tx_data_ready_i : uart_tx ready
//   tx_data_o       : byte to uart_tx
//   tx_data_valid_o : byte valid
//   pending_o       : holding slot k full
//   grant_o         : one-hot source being sent, 0 when idle
//   busy_o          : FSM not idle
//   drop_cnt_o      : saturating count of dropped requests
module uart_printf_arbiter
    import uart_printf_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_NUM = 1,
    parameter int unsigned DROP_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           printf_i,
    input  logic [NUM_REQ*DATA_NUM*8-1:0] send_data_i,
    input  logic                         tx_data_ready_i,
    output logic [7:0]                   tx_data_o,
    output logic                         tx_data_valid_o,
    output logic [NUM_REQ-1:0]           pending_o,
    output logic [NUM_REQ-1:0]           grant_o,
    output logic                         busy_o,
    output logic [DROP_W-1:0]            drop_cnt_o
);

    localparam int unsigned DATA_W = DATA_NUM * 8;
    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W  = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;

    state_t                           state_q, state_d;
    logic [NUM_REQ-1:0][DATA_W-1:0]   hold_q, hold_d;
    logic [NUM_REQ-1:0]               pending_q, pending_d;
    logic [NUM_REQ-1:0]               grant_q, grant_d;
    logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [DATA_W-1:0]                shift_q, shift_d;
    logic [7:0]                       tx_data_q, tx_data_d;
    logic                             tx_valid_q, tx_valid_d;
    logic                             busy_q, busy_d;
    logic [DROP_W-1:0]                drop_q, drop_d;

    logic [NUM_REQ-1:0]               arb_grant_c;
    logic [PTR_W-1:0]                 arb_idx_c;
    logic                             arb_any_c;
    logic                             granting_c;
    logic                             accept_c;
    logic                             last_c;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req     (pending_q),
        .ptr     (rr_ptr_q),
        .grant_c (arb_grant_c),
        .idx_c   (arb_idx_c),
        .any_c   (arb_any_c)
    );

    // Next-state, datapath and slot bookkeeping.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        pending_d  = pending_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        drop_d     = drop_q;

        granting_c = (state_q == IDLE) && arb_any_c;
        accept_c   = tx_valid_q && tx_data_ready_i;
        last_c     = (cnt_q == CNT_W'(DATA_NUM - 1));

        case (state_q)
            IDLE: begin
                if (arb_any_c) begin
                    shift_d    = hold_q[arb_idx_c];
                    grant_d    = arb_grant_c;
                    rr_ptr_d   = (arb_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx_c + PTR_W'(1);
                    cnt_d      = '0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = hold_q[arb_idx_c][byte_sel(32'd0, DATA_NUM)*8 +: 8];
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (accept_c) begin
                    if (last_c) begin
`ifdef UART_PRINTF_NEWLINE_EN
                        tx_data_d  = ASCII_CR;
                        state_d    = EOL_CR;
`else
                        tx_data_d  = '0;
                        tx_valid_d = 1'b0;
                        grant_d    = '0;
                        state_d    = IDLE;
`endif
                    end else begin
                        cnt_d     = cnt_q + CNT_W'(1);
                        tx_data_d = shift_q[byte_sel(32'(cnt_q) + 32'd1, DATA_NUM)*8 +: 8];
                    end
                end
            end
`ifdef UART_PRINTF_NEWLINE_EN
            EOL_CR: begin
                if (accept_c) begin
                    tx_data_d = ASCII_LF;
                    state_d   = EOL_LF;
                end
            end
            EOL_LF: begin
                if (accept_c) begin
                    tx_data_d  = '0;
                    tx_valid_d = 1'b0;
                    grant_d    = '0;
                    state_d    = IDLE;
                end
            end
`endif
            default: begin
                tx_data_d  = '0;
                tx_valid_d = 1'b0;
                grant_d    = '0;
                state_d    = IDLE;
            end
        endcase

        // Winner's slot empties; a strobe on the same edge refills it without a drop.
        if (granting_c) pending_d[arb_idx_c] = 1'b0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (printf_i[k]) begin
                if (!pending_q[k] || (granting_c && arb_grant_c[k])) begin
                    hold_d[k]    = send_data_i[k*DATA_W +: DATA_W];
                    pending_d[k] = 1'b1;
                end else if (drop_d != '1) begin
                    drop_d = drop_d + DROP_W'(1);
                end
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            pending_q  <= '0;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            shift_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            pending_q  <= pending_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
        end
    end

    assign tx_data_o       = tx_data_q;
    assign tx_data_valid_o = tx_valid_q;
    assign pending_o       = pending_q;
    assign grant_o         = grant_q;
    assign busy_o          = busy_q;
    assign drop_cnt_o      = drop_q;

endmodule

// File: tb/tb_uart_printf_arbiter.sv
// Directed self-checking bench for uart_printf_arbiter (NUM_REQ=4, DATA_NUM=2).
// Expectations follow UART_PRINTF_NEWLINE_EN when it is defined.
module tb_uart_printf_arbiter;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned DATA_NUM = 2;
    localparam int unsigned DROP_W   = 8;

    logic                            clk;
    logic                            rst_n;
    logic [NUM_REQ-1:0]              printf_i;
    logic [NUM_REQ*DATA_NUM*8-1:0]   send_data_i;
    logic                            tx_data_ready_i;
    logic [7:0]                      tx_data_o;
    logic                            tx_data_valid_o;
    logic [NUM_REQ-1:0]              pending_o;
    logic [NUM_REQ-1:0]              grant_o;
    logic                            busy_o;
    logic [DROP_W-1:0]               drop_cnt_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    uart_printf_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_NUM (DATA_NUM),
        .DROP_W   (DROP_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .printf_i        (printf_i),
        .send_data_i     (send_data_i),
        .tx_data_ready_i (tx_data_ready_i),
        .tx_data_o       (tx_data_o),
        .tx_data_valid_o (tx_data_valid_o),
        .pending_o       (pending_o),
        .grant_o         (grant_o),
        .busy_o          (busy_o),
        .drop_cnt_o      (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every byte accepted by the sink.
    always @(posedge clk) begin
        if (rst_n && tx_data_valid_o && tx_data_ready_i) rx_q.push_back(tx_data_o);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        printf_i        = '0;
        send_data_i     = '0;
        tx_data_ready_i = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic set_src(input int k, input logic [15:0] d);
        printf_i[k]             = 1'b1;
        send_data_i[k*16 +: 16] = d;
    endtask

    task automatic push_msg(input logic [15:0] d);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
`ifdef UART_PRINTF_NEWLINE_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int t;
        t = 0;
        while (rx_q.size() < n && t < budget) begin
            tick();
            t++;
        end
        n_cmp++;
        if (rx_q.size() < n) begin
            $display("FAIL wait_bytes: got %0d bytes, required %0d", rx_q.size(), n);
            n_err++;
        end
        repeat (5) tick();
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        printf_i        = '0;
        send_data_i     = '0;
        tx_data_ready_i = 1'b1;
        #3;
        n_cmp++; if (tx_data_o !== 8'h00)       begin $display("FAIL reset_data: got %h required 00", tx_data_o); n_err++; end
        n_cmp++; if (tx_data_valid_o !== 1'b0)  begin $display("FAIL reset_valid: got %b required 0", tx_data_valid_o); n_err++; end
        n_cmp++; if (pending_o !== 4'b0000)     begin $display("FAIL reset_pending: got %b required 0000", pending_o); n_err++; end
        n_cmp++; if (grant_o !== 4'b0000)       begin $display("FAIL reset_grant: got %b required 0000", grant_o); n_err++; end
        n_cmp++; if (busy_o !== 1'b0)           begin $display("FAIL reset_busy: got %b required 0", busy_o); n_err++; end
        n_cmp++; if (drop_cnt_o !== 8'd0)       begin $display("FAIL reset_drop: got %0d required 0", drop_cnt_o); n_err++; end
        do_reset();
    endtask

    task automatic test_single();
        logic [7:0] g;
        do_reset();
        set_src(2, 16'h4142);
        tick();
        printf_i = '0;
        n_cmp++; if (pending_o !== 4'b0100)     begin $display("FAIL single_pend: got %b required 0100", pending_o); n_err++; end
        n_cmp++; if (tx_data_valid_o !== 1'b0)  begin $display("FAIL single_early_valid: got %b required 0", tx_data_valid_o); n_err++; end
        tick();
        n_cmp++; if ({tx_data_valid_o, tx_data_o} !== 9'h141) begin $display("FAIL single_first: got %b/%h required 1/41", tx_data_valid_o, tx_data_o); n_err++; end
        n_cmp++; if (grant_o !== 4'b0100)       begin $display("FAIL single_grant: got %b required 0100", grant_o); n_err++; end
        n_cmp++; if (pending_o !== 4'b0000)     begin $display("FAIL single_pend_clr: got %b required 0000", pending_o); n_err++; end
        n_cmp++; if (busy_o !== 1'b1)           begin $display("FAIL single_busy: got %b required 1", busy_o); n_err++; end
        tick();
        n_cmp++; if ({tx_data_valid_o, tx_data_o} !== 9'h142) begin $display("FAIL single_second: got %b/%h required 1/42", tx_data_valid_o, tx_data_o); n_err++; end
        tick();
`ifdef UART_PRINTF_NEWLINE_EN
        n_cmp++; if ({tx_data_valid_o, tx_data_o} !== 9'h10D) begin $display("FAIL single_cr: got %b/%h required 1/0d", tx_data_valid_o, tx_data_o); n_err++; end
`else
        n_cmp++; if ({tx_data_valid_o, grant_o, busy_o} !== 6'b0_0000_0) begin $display("FAIL single_end: got v=%b g=%b b=%b required 0/0000/0", tx_data_valid_o, grant_o, busy_o); n_err++; end
`endif
        push_msg(16'h4142);
        wait_bytes(exp_q.size(), 50);
        n_cmp++; if (rx_q.size() != exp_q.size()) begin $display("FAIL single_len: got %0d required %0d", rx_q.size(), exp_q.size()); n_err++; end
        foreach (exp_q[i]) begin
            g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_cmp++; if (g !== exp_q[i]) begin $display("FAIL single_byte%0d: got %h required %h", i, g, exp_q[i]); n_err++; end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] g;
        do_reset();
        set_src(0, 16'h3030);
        set_src(1, 16'h3131);
        set_src(2, 16'h3232);
        set_src(3, 16'h3333);
        tick();
        printf_i = '0;
        n_cmp++; if (pending_o !== 4'b1111) begin $display("FAIL rr_pend_all: got %b required 1111", pending_o); n_err++; end
        tick();
        n_cmp++; if (grant_o !== 4'b0001)   begin $display("FAIL rr_grant0: got %b required 0001", grant_o); n_err++; end
        push_msg(16'h3030); push_msg(16'h3131); push_msg(16'h3232); push_msg(16'h3333);
        wait_bytes(exp_q.size(), 200);
        set_src(3, 16'h6364);
        set_src(1, 16'h6162);
        tick();
        printf_i = '0;
        tick();
        n_cmp++; if (grant_o !== 4'b0010)   begin $display("FAIL rr_grant1: got %b required 0010", grant_o); n_err++; end
        push_msg(16'h6162); push_msg(16'h6364);
        wait_bytes(exp_q.size(), 200);
        n_cmp++; if (rx_q.size() != exp_q.size()) begin $display("FAIL rr_len: got %0d required %0d", rx_q.size(), exp_q.size()); n_err++; end
        foreach (exp_q[i]) begin
            g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_cmp++; if (g !== exp_q[i]) begin $display("FAIL rr_byte%0d: got %h required %h", i, g, exp_q[i]); n_err++; end
        end
    endtask

    task automatic test_drop();
        logic [7:0] g;
        do_reset();
        tx_data_ready_i = 1'b0;
        set_src(0, 16'h1111);
        tick();
        printf_i = '0;
        tick();
        set_src(1, 16'h2222);
        tick();
        printf_i = '0;
        n_cmp++; if (pending_o !== 4'b0010) begin $display("FAIL drop_pend: got %b required 0010", pending_o); n_err++; end
        set_src(1, 16'h3333);
        tick();
        printf_i = '0;
        n_cmp++; if (drop_cnt_o !== 8'd1)   begin $display("FAIL drop_one: got %0d required 1", drop_cnt_o); n_err++; end
        set_src(1, 16'h4444);
        repeat (299) tick();
        printf_i = '0;
        tick();
        n_cmp++; if (drop_cnt_o !== 8'd255) begin $display("FAIL drop_sat: got %0d required 255", drop_cnt_o); n_err++; end
        n_cmp++; if ({tx_data_valid_o, tx_data_o} !== 9'h111) begin $display("FAIL drop_stall: got %b/%h required 1/11", tx_data_valid_o, tx_data_o); n_err++; end
        tx_data_ready_i = 1'b1;
        push_msg(16'h1111); push_msg(16'h2222);
        wait_bytes(exp_q.size(), 100);
        n_cmp++; if (drop_cnt_o !== 8'd255) begin $display("FAIL drop_hold: got %0d required 255", drop_cnt_o); n_err++; end
        n_cmp++; if (rx_q.size() != exp_q.size()) begin $display("FAIL drop_len: got %0d required %0d", rx_q.size(), exp_q.size()); n_err++; end
        foreach (exp_q[i]) begin
            g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_cmp++; if (g !== exp_q[i]) begin $display("FAIL drop_byte%0d: got %h required %h", i, g, exp_q[i]); n_err++; end
        end
    endtask

    task automatic test_stall();
        logic [7:0] g;
        do_reset();
        tx_data_ready_i = 1'b0;
        set_src(0, 16'h4142);
        tick();
        printf_i = '0;
        tick();
        for (int c = 0; c < 50; c++) begin
            n_cmp++; if ({tx_data_valid_o, tx_data_o} !== 9'h141) begin $display("FAIL stall_c%0d: got %b/%h required 1/41", c, tx_data_valid_o, tx_data_o); n_err++; end
            tick();
        end
        tx_data_ready_i = 1'b1;
        tick();
        n_cmp++; if ({tx_data_valid_o, tx_data_o} !== 9'h142) begin $display("FAIL stall_release: got %b/%h required 1/42", tx_data_valid_o, tx_data_o); n_err++; end
        push_msg(16'h4142);
        wait_bytes(exp_q.size(), 50);
        n_cmp++; if (rx_q.size() != exp_q.size()) begin $display("FAIL stall_len: got %0d required %0d", rx_q.size(), exp_q.size()); n_err++; end
        foreach (exp_q[i]) begin
            g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_cmp++; if (g !== exp_q[i]) begin $display("FAIL stall_byte%0d: got %h required %h", i, g, exp_q[i]); n_err++; end
        end
    endtask

    task automatic test_collision();
        logic [7:0] g;
        do_reset();
        set_src(0, 16'h1234);
        tick();
        set_src(0, 16'h5A5A);
        tick();
        printf_i = '0;
        n_cmp++; if (pending_o !== 4'b0001) begin $display("FAIL coll_pend: got %b required 0001", pending_o); n_err++; end
        n_cmp++; if ({tx_data_valid_o, tx_data_o} !== 9'h112) begin $display("FAIL coll_first: got %b/%h required 1/12", tx_data_valid_o, tx_data_o); n_err++; end
        n_cmp++; if (drop_cnt_o !== 8'd0)   begin $display("FAIL coll_drop: got %0d required 0", drop_cnt_o); n_err++; end
        push_msg(16'h1234); push_msg(16'h5A5A);
        wait_bytes(exp_q.size(), 100);
        n_cmp++; if (drop_cnt_o !== 8'd0)   begin $display("FAIL coll_drop_end: got %0d required 0", drop_cnt_o); n_err++; end
        n_cmp++; if (rx_q.size() != exp_q.size()) begin $display("FAIL coll_len: got %0d required %0d", rx_q.size(), exp_q.size()); n_err++; end
        foreach (exp_q[i]) begin
            g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_cmp++; if (g !== exp_q[i]) begin $display("FAIL coll_byte%0d: got %h required %h", i, g, exp_q[i]); n_err++; end
        end
    endtask

    task automatic test_eol_abort();
        logic [7:0] g;
        do_reset();
        set_src(0, 16'h4F4B);
        tick();
        printf_i = '0;
        push_msg(16'h4F4B);
        wait_bytes(exp_q.size(), 50);
        set_src(2, 16'h4F4B);
        tick();
        printf_i = '0;
        tick();
        tick();
        // 0x4F accepted; abort while 0x4B is on the bus
        exp_q.push_back(8'h4F);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({tx_data_valid_o, tx_data_o} !== 9'h000) begin $display("FAIL abort_tx: got %b/%h required 0/00", tx_data_valid_o, tx_data_o); n_err++; end
        n_cmp++; if ({pending_o, grant_o, busy_o} !== 9'h000) begin $display("FAIL abort_ctl: got p=%b g=%b b=%b required 0", pending_o, grant_o, busy_o); n_err++; end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        n_cmp++; if (tx_data_valid_o !== 1'b0) begin $display("FAIL abort_resend: got valid %b required 0", tx_data_valid_o); n_err++; end
        n_cmp++; if (rx_q.size() != exp_q.size()) begin $display("FAIL eol_len: got %0d required %0d", rx_q.size(), exp_q.size()); n_err++; end
        foreach (exp_q[i]) begin
            g = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_cmp++; if (g !== exp_q[i]) begin $display("FAIL eol_byte%0d: got %h required %h", i, g, exp_q[i]); n_err++; end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_stall();
        test_collision();
        test_eol_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_printf_arbiter.md
Name: uart_printf_arbiter

Overview:
- Shares the single uart_tx byte channel between up to NUM_REQ debug "printf" sources (DM wishbone slave, wishbone master, JTAG TAP, RISC-V CPU).
- Each source pulses printf with a DATA_NUM-byte send_data word. The block captures it into a one-deep holding slot per source, picks a winner round-robin, and serializes the bytes MSB-first into uart_tx over the valid/ready handshake.
- Replaces the current compile-time selection of a single printf source.

Parameters:
- NUM_REQ, 4, number of printf sources.
- DATA_NUM, 1, bytes per message.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock (sys_clk, 27 MHz).
- rst_n  in  1  asynchronous active-low reset.
- printf_i  in  NUM_REQ  per-source 1-cycle request strobe.
- send_data_i  in  NUM_REQ*DATA_NUM*8  source k occupies slice [k*DATA_NUM*8 +: DATA_NUM*8].
- tx_data_ready_i  in  1  from uart_tx; byte accepted on a clock edge where valid and ready are both 1.
- tx_data_o  out  8  byte to uart_tx.
- tx_data_valid_o  out  1  byte valid.
- pending_o  out  NUM_REQ  holding slot k full.
- grant_o  out  NUM_REQ  one-hot source currently being sent; 0 when idle.
- busy_o  out  1  state != IDLE.
- drop_cnt_o  out  DROP_W  saturating count of dropped requests.

Behaviour:
- Reset (async, rst_n=0): state IDLE; tx_data_o=0; tx_data_valid_o=0; pending_o=0; grant_o=0; busy_o=0; drop_cnt_o=0; rr pointer=0; holding slots=0.
- Capture:
  - printf_i[k]=1 at edge N with pending[k]=0: hold[k]<=slice k, and pending[k]=1 from N+1.
  - printf_i[k]=1 with pending[k]=1 (and not being granted this cycle): request dropped, hold[k] unchanged, drop_cnt+1, saturating at all-ones.
  - Several strobes in the same cycle are all captured independently.
- Grant (IDLE with pending!=0):
  - Winner is the first set pending bit scanning from rr_ptr upward, wrapping.
  - On that edge: shift reg<=hold[w]; pending[w]<=0; grant_o<=onehot(w); rr_ptr<=(w+1) mod NUM_REQ; byte count<=0; state->SEND.
- Same-cycle collision: printf_i[w] asserted on the grant edge.
  - Shift reg takes the OLD hold[w].
  - hold[w] takes the new data and pending[w] stays 1.
  - No drop is counted.
- SEND:
  - tx_data_valid_o=1 and tx_data_o = byte (DATA_NUM-1-cnt), i.e. MSB byte first.
  - valid stays high and data stays stable until the valid&&ready edge.
  - On each accepted edge cnt++. When the last byte (cnt==DATA_NUM-1) is accepted: state->IDLE, valid<=0, grant_o<=0.
  - Next grant no earlier than the following cycle, so there is at least one idle cycle between messages.
- Latency: printf at edge N with the block idle gives the first valid byte at cycle N+2.
- While ready is held low, valid stays asserted indefinitely; no timeout.
- Reset mid-message aborts immediately; partial bytes are not resent.
- The rr pointer advances only on grant, so starvation-free: each pending source is served within NUM_REQ messages.

Optional Feature:
- UART_PRINTF_NEWLINE_EN defined:
  - After the last data byte, state passes through EOL_CR (0x0D) then EOL_LF (0x0A), each with the same handshake, before IDLE.
  - grant_o and busy_o are held through both.
- Undefined: only the DATA_NUM data bytes are sent, and the EOL states do not exist.

Decomposition:
- Package uart_printf_pkg holds:
  - state enum IDLE/SEND/EOL_CR/EOL_LF, 2 bits.
  - localparams ASCII_CR=8'h0D and ASCII_LF=8'h0A.
  - a function for the byte index MSB-first.
- One sub-module, rr_arbiter (NUM_REQ): combinational rotate-priority-rotate back.
  - Inputs: req, ptr.
  - Outputs: onehot grant and binary index.
- Holding slots, FSM and counters live in the top of uart_printf_arbiter.

Test Plan:
- NUM_REQ=4, DATA_NUM=2, ready tied 1; pulse printf_i[2] with slice 16'h4142 -> bytes 0x41 then 0x42, grant_o=4'b0100, first valid at N+2, pending_o returns to 0.
- Strobe all four sources in one cycle with data 16'h3030/3131/3232/3333 -> sent in order src0,1,2,3; next round starting from rr_ptr=0 with srcs 3 and 1 pending sends src1 then src3.
- Source 1 strobed twice while pending (not granted) -> second dropped, drop_cnt_o=1, original data sent; force 300 drops with DROP_W=8 -> drop_cnt_o saturates at 255.
- Hold ready=0 for 50 cycles during SEND -> valid and tx_data_o stable at 0x41 throughout; releasing ready advances to 0x42.
- Strobe src0 on its own grant edge with new data 16'h5A5A -> old message is sent, then 0x5A 0x5A, and drop_cnt_o stays 0.
- With UART_PRINTF_NEWLINE_EN: send 16'h4F4B -> 0x4F, 0x4B, 0x0D, 0x0A; assert rst_n=0 mid-message -> all outputs zero asynchronously, and nothing is resent after release.
